motion_scheduler: RTL and testbench

Per-frame motion engine for all on-screen sprites. On each frame tick, it walks sprites 0..N_SPRITES-1 through one shared add/clamp datapath, one sprite every two clocks. Sprite 0 is the player: its velocity comes from the keyboard keycode latched at frame start. The other sprites move at velocities loaded through a valid/ready config port. It sits between the USB keycode register and the color mapper, and replaces per-sprite free-running motion logic.

---
 rtl/motion_pkg.sv | 10 +
 rtl/motion_axis_step.sv | 21 ++
 rtl/motion_scheduler.sv | 125 ++++++++++++
 tb/tb_motion_scheduler.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// motion_pkg: shared types, FSM states and keycode constants for motion_scheduler
package motion_pkg;
  typedef logic [9:0] coord_t;
  typedef logic signed [9:0] vel_t;
  typedef enum logic [2:0] {IDLE, LATCH, READ, WRITE, DONE} state_t;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
endpackage

// File: rtl/motion_axis_step.sv
// motion_axis_step: one-axis add/clamp with edge-hit flag
// Ports: pos (unsigned coord), vel (two's complement), lo/hi (legal centre range),
//        new_pos (clamped result), hit (result was clamped at lo or hi)
module motion_axis_step
  import motion_pkg::*;
(
  input  logic [9:0] pos,
  input  logic [9:0] vel,
  input  logic [9:0] lo,
  input  logic [9:0] hi,
  output logic [9:0] new_pos,
  output logic       hit
);
  logic signed [10:0] sum;
  logic lo_hit, hi_hit;
  assign sum = $signed({1'b0, pos}) + $signed({vel[9], vel});
  assign lo_hit = sum < $signed({1'b0, lo});
  assign hi_hit = sum > $signed({1'b0, hi});
  assign new_pos = lo_hit ? lo : hi_hit ? hi : coord_t'(sum[9:0]);
  assign hit = lo_hit | hi_hit;
endmodule

// File: rtl/motion_scheduler.sv
// motion_scheduler: per-frame sprite motion engine, one sprite every two clocks
// Ports: Clk/Reset_n (async active-low), frame_tick (per-vsync pulse), keycode (player key),
//        cfg_valid/cfg_ready/cfg_idx/cfg_x/cfg_y/cfg_vx/cfg_vy (sprite config write),
//        pos_x/pos_y (packed positions, sprite i at [10i+9:10i]), busy, done, overrun (sticky).
// Build option: MOTION_SCHED_BOUNCE_EN makes non-player sprites reflect off edges
//               instead of stopping on that axis.
module motion_scheduler
  import motion_pkg::*;
#(
  parameter int N_SPRITES = 4,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int SIZE      = 4,
  parameter int STEP      = 2,
  parameter int X_CENTER  = 320,
  parameter int Y_CENTER  = 240
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_tick,
  input  logic [7:0]             keycode,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [3:0]             cfg_idx,
  input  logic [9:0]             cfg_x,
  input  logic [9:0]             cfg_y,
  input  logic [9:0]             cfg_vx,
  input  logic [9:0]             cfg_vy,
  output logic [10*N_SPRITES-1:0] pos_x,
  output logic [10*N_SPRITES-1:0] pos_y,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);
  localparam logic [3:0] LAST = 4'(N_SPRITES - 1);
  localparam coord_t X_LO = 10'(SIZE);
  localparam coord_t X_HI = 10'(X_MAX - SIZE);
  localparam coord_t Y_LO = 10'(SIZE);
  localparam coord_t Y_HI = 10'(Y_MAX - SIZE);
  localparam vel_t STEP_V = 10'(STEP);
  state_t state, state_nx;
  logic [3:0] idx;
  // Sized to the full 4-bit index space so idx/cfg_idx index cleanly; entries >= N_SPRITES stay idle.
  coord_t px [16];
  coord_t py [16];
  vel_t   vx [16];
  vel_t   vy [16];
  coord_t op_px, op_py, nx, ny;
  vel_t   op_vx, op_vy, nvx, nvy, kvx, kvy;
  logic   hx, hy;
  motion_axis_step u_x (.pos(op_px), .vel(op_vx), .lo(X_LO), .hi(X_HI), .new_pos(nx), .hit(hx));
  motion_axis_step u_y (.pos(op_py), .vel(op_vy), .lo(Y_LO), .hi(Y_HI), .new_pos(ny), .hit(hy));
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  always_comb begin
    busy      = state != IDLE;
    done      = state == DONE;
    cfg_ready = state == IDLE && !frame_tick;
    state_nx  = state == IDLE  ? (frame_tick ? LATCH : IDLE) :
                state == LATCH ? READ :
                state == READ  ? WRITE :
                state == WRITE ? (idx == LAST ? DONE : READ) : IDLE;
  end
  always_comb begin
    kvx = keycode == KEY_A ? -STEP_V : keycode == KEY_D ? STEP_V : '0;
    kvy = keycode == KEY_W ? -STEP_V : keycode == KEY_S ? STEP_V : '0;
  end
`ifdef MOTION_SCHED_BOUNCE_EN
  assign nvx = hx ? -op_vx : op_vx;
  assign nvy = hy ? -op_vy : op_vy;
`else
  assign nvx = hx ? '0 : op_vx;
  assign nvy = hy ? '0 : op_vy;
`endif
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        px[i] <= 10'(X_CENTER);
        py[i] <= 10'(Y_CENTER);
        vx[i] <= '0;
        vy[i] <= '0;
      end
      op_px   <= '0;
      op_py   <= '0;
      op_vx   <= '0;
      op_vy   <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (frame_tick && busy) overrun <= 1'b1;
      if (cfg_valid && cfg_ready && cfg_idx <= LAST) begin
        px[cfg_idx] <= cfg_x;
        py[cfg_idx] <= cfg_y;
        vx[cfg_idx] <= cfg_vx;
        vy[cfg_idx] <= cfg_vy;
      end
      if (state == LATCH) begin
        vx[0] <= kvx;
        vy[0] <= kvy;
        idx   <= '0;
      end
      if (state == READ) begin
        op_px <= px[idx];
        op_py <= py[idx];
        op_vx <= vx[idx];
        op_vy <= vy[idx];
      end
      if (state == WRITE) begin
        px[idx] <= nx;
        py[idx] <= ny;
        // The player keeps its key-derived velocity; only other sprites react to edges.
        if (idx != 4'd0) begin
          vx[idx] <= nvx;
          vy[idx] <= nvy;
        end
        idx <= idx == LAST ? 4'd0 : idx + 4'd1;
      end
    end
  end
  for (genvar g = 0; g < N_SPRITES; g++) begin : g_pack
    assign pos_x[10*g +: 10] = px[g];
    assign pos_y[10*g +: 10] = py[g];
  end
endmodule

// File: tb/tb_motion_scheduler.sv
// tb_motion_scheduler: scoreboard bench for motion_scheduler
module tb_motion_scheduler;
  import motion_pkg::*;
  localparam int N = 4, XM = 639, YM = 479, SZ = 4, ST = 2, XC = 320, YC = 240;
`ifdef MOTION_SCHED_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif
  logic Clk = 1'b0, Reset_n = 1'b0, frame_tick = 1'b0, cfg_valid = 1'b0;
  logic [7:0] keycode = '0;
  logic [3:0] cfg_idx = '0;
  logic [9:0] cfg_x = '0, cfg_y = '0, cfg_vx = '0, cfg_vy = '0;
  logic cfg_ready, busy, done, overrun;
  logic [10*N-1:0] pos_x, pos_y;
  motion_scheduler #(.N_SPRITES(N), .X_MAX(XM), .Y_MAX(YM), .SIZE(SZ), .STEP(ST),
                     .X_CENTER(XC), .Y_CENTER(YC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_vx(cfg_vx), .cfg_vy(cfg_vy),
    .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .done(done), .overrun(overrun));
  always #5 Clk = ~Clk;
  int n_checks = 0, n_errors = 0, done_cnt = 0;
  typedef struct { logic [10*N-1:0] px, py; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int mx[N], my[N], mvx[N], mvy[N];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [10*N-1:0] packed_pos(input bit y);
    logic [10*N-1:0] r;
    for (int i = 0; i < N; i++) r[10*i +: 10] = 10'(y ? my[i] : mx[i]);
    return r;
  endfunction
  task automatic axis(input int p, input int v, input int lim, output int np, output bit hit);
    int s;
    s = p + v;
    hit = 1'b1;
    if (s < SZ) np = SZ;
    else if (s > lim - SZ) np = lim - SZ;
    else begin
      np = s;
      hit = 1'b0;
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = XC; my[i] = YC; mvx[i] = 0; mvy[i] = 0;
    end
  endtask
  task automatic model_pass(input logic [7:0] key);
    int nx, ny;
    bit hx, hy;
    mvx[0] = key == 8'h04 ? -ST : key == 8'h07 ? ST : 0;
    mvy[0] = key == 8'h1A ? -ST : key == 8'h16 ? ST : 0;
    for (int i = 0; i < N; i++) begin
      axis(mx[i], mvx[i], XM, nx, hx);
      axis(my[i], mvy[i], YM, ny, hy);
      mx[i] = nx;
      my[i] = ny;
      if (i > 0 && hx) mvx[i] = BOUNCE ? -mvx[i] : 0;
      if (i > 0 && hy) mvy[i] = BOUNCE ? -mvy[i] : 0;
    end
    q.push_back('{packed_pos(1'b0), packed_pos(1'b1)});
  endtask
  always @(negedge Clk)
    if (Reset_n && done) begin
      done_cnt++;
      check("done_has_expect", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("pass_pos_x", 64'(pos_x), 64'(mon_e.px));
        check("pass_pos_y", 64'(pos_y), 64'(mon_e.py));
      end
    end
  task automatic start_tick(input logic [7:0] key);
    keycode = key;
    frame_tick = 1'b1;
    model_pass(key);
    @(negedge Clk);
    frame_tick = 1'b0;
  endtask
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge Clk);
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask
  task automatic run_tick(input logic [7:0] key);
    int c;
    start_tick(key);
    wait_idle(c);
    check("pass_len", 64'(c), 64'(2*N+2));
  endtask
  task automatic cfg_write(input int idx, input int x, input int y, input int vx, input int vy);
    cfg_idx = 4'(idx); cfg_x = 10'(x); cfg_y = 10'(y); cfg_vx = 10'(vx); cfg_vy = 10'(vy);
    cfg_valid = 1'b1;
    #1 check("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    @(negedge Clk);
    cfg_valid = 1'b0;
    if (idx < N) begin
      mx[idx] = x; my[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_overrun"}, 64'(overrun), 64'd0);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, "_pos_x"}, 64'(pos_x), 64'(packed_pos(1'b0)));
    check({tag, "_pos_y"}, 64'(pos_y), 64'(packed_pos(1'b1)));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, d0, wrap;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset");
    Reset_n = 1'b1;
    @(negedge Clk);
    d0 = done_cnt;
    run_tick(KEY_D);
    check("d_p0x", 64'(pos_x[9:0]), 64'd322);
    check("d_p0y", 64'(pos_y[9:0]), 64'd240);
    check("d_others_x", 64'(pos_x[10*N-1:10]), 64'({(N-1){10'd320}}));
    check("d_others_y", 64'(pos_y[10*N-1:10]), 64'({(N-1){10'd240}}));
    check("d_done_once", 64'(done_cnt - d0), 64'd1);
    cfg_write(1, 633, 100, 5, 0);
    check("cfg_pos_now", 64'(pos_x[19:10]), 64'd633);
    cfg_write(9, 11, 12, 1, 1);
    run_tick(8'h00);
    check("s1_clamp_x", 64'(pos_x[19:10]), 64'd635);
    check("p0_idle_x", 64'(pos_x[9:0]), 64'd322);
    run_tick(8'h00);
`ifdef MOTION_SCHED_BOUNCE_EN
    check("s1_bounce_x", 64'(pos_x[19:10]), 64'd630);
`else
    check("s1_stop_x", 64'(pos_x[19:10]), 64'd635);
`endif
    d0 = done_cnt;
    start_tick(KEY_S);
    repeat (2) @(negedge Clk);
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    wait_idle(c);
    check("overrun_done_once", 64'(done_cnt - d0), 64'd1);
    check("overrun_sticky", 64'(overrun), 64'd1);
    check("overrun_p0y", 64'(pos_y[9:0]), 64'd242);
    start_tick(KEY_W);
    cfg_idx = 4'd2; cfg_x = 10'd100; cfg_y = 10'd200; cfg_vx = 10'd1; cfg_vy = 10'd1;
    cfg_valid = 1'b1;
    #1 check("cfg_ready_busy", 64'(cfg_ready), 64'd0);
    c = 0;
    while (!cfg_ready && c < 100) begin
      @(negedge Clk);
      c++;
    end
    check("cfg_wait", 64'(c), 64'(2*N+2));
    check("cfg_not_yet", 64'(pos_x[29:20]), 64'(mx[2]));
    @(negedge Clk);
    cfg_valid = 1'b0;
    mx[2] = 100; my[2] = 200; mvx[2] = 1; mvy[2] = 1;
    check("cfg_landed_x", 64'(pos_x[29:20]), 64'd100);
    check("cfg_landed_y", 64'(pos_y[29:20]), 64'd200);
    cfg_idx = 4'd3; cfg_x = 10'd50; cfg_y = 10'd60; cfg_vx = '0; cfg_vy = '0;
    keycode = 8'h00;
    cfg_valid = 1'b1;
    frame_tick = 1'b1;
    model_pass(8'h00);
    #1 check("cfg_ready_tick", 64'(cfg_ready), 64'd0);
    @(negedge Clk);
    frame_tick = 1'b0;
    cfg_valid = 1'b0;
    check("tick_won_busy", 64'(busy), 64'd1);
    wait_idle(c);
    check("held_off_x", 64'(pos_x[39:30]), 64'(mx[3]));
    check("s2_moved_x", 64'(pos_x[29:20]), 64'd101);
    start_tick(KEY_D);
    repeat (6) @(negedge Clk);
    check("mid_busy", 64'(busy), 64'd1);
    Reset_n = 1'b0;
    q.delete();
    model_reset();
    #1 check_reset_outputs("midreset");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    d0 = done_cnt;
    run_tick(KEY_D);
    check("clean_p0x", 64'(pos_x[9:0]), 64'd322);
    check("clean_s2x", 64'(pos_x[29:20]), 64'd320);
    check("clean_done_once", 64'(done_cnt - d0), 64'd1);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    @(negedge Clk);
    wrap = 0;
    for (int i = 0; i < 200; i++) begin
      run_tick(KEY_A);
      if (pos_x[9:0] > 10'd320 || pos_x[9:0] < 10'd4) wrap++;
    end
    check("sat_x", 64'(pos_x[9:0]), 64'd4);
    check("no_wrap", 64'(wrap), 64'd0);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
